// File: rtl/mc_residual_engine_pkg.sv
// Shared types and elaboration-time helpers for the motion-compensation residual engine.
// No logic; widths, window origin and position clamping only.
// Not applicable: no handshakes in this package.
package mc_pkg;

    typedef enum logic [1:0] {IDLE, CALC, OUT} mc_state_e;

    function automatic int res_width(input int pixel_width);
        return pixel_width + 1;
    endfunction

    function automatic int row_sum_width(input int pixel_width, input int mb_size);
        return pixel_width + $clog2(mb_size);
    endfunction

    function automatic int sad_width(input int pixel_width, input int mb_size);
        return pixel_width + 2 * $clog2(mb_size);
    endfunction

    function automatic int origin(input int ref_size, input int mb_size);
        return (ref_size - mb_size) / 2;
    endfunction

    function automatic int clamp_pos(input int pos, input int max);
        if (pos < 0)
            return 0;
        if (pos > max)
            return max;
        return pos;
    endfunction

endpackage

// File: rtl/mc_residual_engine_row_sad.sv
// One-row residual and absolute-sum datapath.
// Latency: combinational.
// Backpressure: none; the engine sequences rows.
module mc_row_sad
    import mc_pkg::*;
#(
    parameter int  MB_SIZE     = 4,
    parameter int  PIXEL_WIDTH = 8,
    localparam int RES_WIDTH   = res_width(PIXEL_WIDTH),
    localparam int SUM_WIDTH   = row_sum_width(PIXEL_WIDTH, MB_SIZE)
) (
    input  logic [PIXEL_WIDTH-1:0]      curr_row [MB_SIZE],
    input  logic [PIXEL_WIDTH-1:0]      pred_row [MB_SIZE],
    output logic signed [RES_WIDTH-1:0] res_row  [MB_SIZE],
    output logic [SUM_WIDTH-1:0]        abs_sum
);

    // Both operands are unsigned pixels, so one extra bit keeps the difference exact.
    always_comb begin
        abs_sum = '0;
        for (int c = 0; c < MB_SIZE; c++) begin
            res_row[c] = $signed({1'b0, curr_row[c]}) - $signed({1'b0, pred_row[c]});
            abs_sum    = abs_sum + SUM_WIDTH'(res_row[c][RES_WIDTH-1] ? -res_row[c] : res_row[c]);
        end
    end

endmodule

// File: rtl/mc_residual_engine.sv
// Motion-compensated residual + SAD: crops a clamped-MV prediction, emits one residual row per cycle.
// Latency: dst_valid rises MB_SIZE edges after the accept edge; one block per MB_SIZE+2 cycles.
// Backpressure: outputs hold while dst_valid && !dst_ready; src_ready only in IDLE.
module mc_residual_engine
    import mc_pkg::*;
#(
    parameter int  MB_SIZE     = 4,
    parameter int  PIXEL_WIDTH = 8,
    parameter int  REF_SIZE    = 16,
    parameter int  MV_WIDTH    = 6,
    localparam int RES_WIDTH   = res_width(PIXEL_WIDTH),
    localparam int SAD_WIDTH   = sad_width(PIXEL_WIDTH, MB_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic                        mode,
    input  logic signed [MV_WIDTH-1:0]  mv_x,
    input  logic signed [MV_WIDTH-1:0]  mv_y,
    input  logic [PIXEL_WIDTH-1:0]      ref_frame [REF_SIZE][REF_SIZE],
    input  logic [PIXEL_WIDTH-1:0]      curr_mb   [MB_SIZE][MB_SIZE],
    output logic                        dst_valid,
    input  logic                        dst_ready,
    output logic signed [RES_WIDTH-1:0] residual  [MB_SIZE][MB_SIZE],
    output logic [SAD_WIDTH-1:0]        sad,
    output logic                        mv_clamped
);

    localparam int POS_W   = MV_WIDTH + $clog2(REF_SIZE) + 1;
    localparam int MAX_POS = REF_SIZE - MB_SIZE;
    localparam int IDX_W   = $clog2(REF_SIZE);
    localparam int ROW_W   = $clog2(MB_SIZE);
    localparam int SUM_W   = row_sum_width(PIXEL_WIDTH, MB_SIZE);
    localparam logic [PIXEL_WIDTH-1:0] FLAT_PRED = PIXEL_WIDTH'(1) << (PIXEL_WIDTH - 1);

    mc_state_e state, state_nxt;

    logic [ROW_W-1:0]       row;
    logic                   accept;
    logic                   row_last;
    logic signed [POS_W-1:0] px, py;
    logic [IDX_W-1:0]       px_c, py_c;
    logic                   clamp_hit;

    logic [PIXEL_WIDTH-1:0] curr_q    [MB_SIZE][MB_SIZE];
    logic [PIXEL_WIDTH-1:0] pred_q    [MB_SIZE][MB_SIZE];
    logic [PIXEL_WIDTH-1:0] pred_crop [MB_SIZE][MB_SIZE];
    logic [PIXEL_WIDTH-1:0] curr_row  [MB_SIZE];
    logic [PIXEL_WIDTH-1:0] pred_row  [MB_SIZE];
    logic signed [RES_WIDTH-1:0] res_row [MB_SIZE];
    logic [SUM_W-1:0]       row_sum;

    assign accept   = (state == IDLE) && src_valid && src_ready;
    assign row_last = (row == ROW_W'(MB_SIZE - 1));

    // Window crop: the position is widened so ORIGIN + mv never wraps before clamping.
    always_comb begin
        px        = POS_W'(origin(REF_SIZE, MB_SIZE)) + POS_W'(mv_x);
        py        = POS_W'(origin(REF_SIZE, MB_SIZE)) + POS_W'(mv_y);
        px_c      = IDX_W'(clamp_pos(int'(px), MAX_POS));
        py_c      = IDX_W'(clamp_pos(int'(py), MAX_POS));
        clamp_hit = (clamp_pos(int'(px), MAX_POS) != int'(px)) ||
                    (clamp_pos(int'(py), MAX_POS) != int'(py));
        for (int r = 0; r < MB_SIZE; r++)
            for (int c = 0; c < MB_SIZE; c++)
                pred_crop[r][c] = ref_frame[py_c + IDX_W'(r)][px_c + IDX_W'(c)];
    end

    always_comb begin
        for (int c = 0; c < MB_SIZE; c++) begin
            curr_row[c] = curr_q[row][c];
            pred_row[c] = pred_q[row][c];
        end
    end

    mc_row_sad #(
        .MB_SIZE     (MB_SIZE),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_row_sad (
        .curr_row (curr_row),
        .pred_row (pred_row),
        .res_row  (res_row),
        .abs_sum  (row_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (row_last)  state_nxt = OUT;
            OUT:     if (dst_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Block operands are captured once; flat mode folds the constant prediction in here.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < MB_SIZE; r++)
                for (int c = 0; c < MB_SIZE; c++) begin
                    curr_q[r][c] <= curr_mb[r][c];
                    pred_q[r][c] <= mode ? FLAT_PRED : pred_crop[r][c];
                end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ready  <= 1'b0;
            dst_valid  <= 1'b0;
            sad        <= '0;
            mv_clamped <= 1'b0;
            row        <= '0;
            for (int r = 0; r < MB_SIZE; r++)
                for (int c = 0; c < MB_SIZE; c++)
                    residual[r][c] <= '0;
        end else begin
            src_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sad        <= '0;
                        row        <= '0;
                        mv_clamped <= !mode && clamp_hit;
                    end
                end
                CALC: begin
                    for (int c = 0; c < MB_SIZE; c++)
                        residual[row][c] <= res_row[c];
                    sad <= sad + SAD_WIDTH'(row_sum);
                    row <= row + ROW_W'(1);
                    if (row_last)
                        dst_valid <= 1'b1;
                end
                OUT: begin
                    if (dst_ready)
                        dst_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_residual_engine.sv
// Directed scoreboard bench for mc_residual_engine at 4x4/16x16 and 8x8/32x32.
module tb_mc_residual_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic mode, dst_ready;
    logic signed [5:0] mv_x, mv_y;

    logic src_valid4, src_ready4, dst_valid4, mvc4;
    logic [7:0] ref4 [16][16];
    logic [7:0] curr4 [4][4];
    logic signed [8:0] res4 [4][4];
    logic [11:0] sad4;

    logic src_valid8, src_ready8, dst_valid8, mvc8;
    logic [7:0] ref8 [32][32];
    logic [7:0] curr8 [8][8];
    logic signed [8:0] res8 [8][8];
    logic [13:0] sad8;

    mc_residual_engine u_dut4 (
        .clk(clk), .reset(reset), .src_valid(src_valid4), .src_ready(src_ready4),
        .mode(mode), .mv_x(mv_x), .mv_y(mv_y), .ref_frame(ref4), .curr_mb(curr4),
        .dst_valid(dst_valid4), .dst_ready(dst_ready), .residual(res4), .sad(sad4),
        .mv_clamped(mvc4)
    );

    mc_residual_engine #(.MB_SIZE(8), .REF_SIZE(32)) u_dut8 (
        .clk(clk), .reset(reset), .src_valid(src_valid8), .src_ready(src_ready8),
        .mode(mode), .mv_x(mv_x), .mv_y(mv_y), .ref_frame(ref8), .curr_mb(curr8),
        .dst_valid(dst_valid8), .dst_ready(dst_ready), .residual(res8), .sad(sad8),
        .mv_clamped(mvc8)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int m_ref  [32][32];
    int m_curr [8][8];
    int qres4[$], qsad4[$], qclp4[$];
    int qres8[$], qsad8[$], qclp8[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: crop with clamped MV (or flat 128), residual and SAD.
    task automatic model(input int mb, input int rsz, input int md, input int mvx, input int mvy,
                         output int res [64], output int s, output int clp);
        int org, mx, px, py, p;
        org = (rsz - mb) / 2;
        mx  = rsz - mb;
        px  = org + mvx;
        py  = org + mvy;
        clp = 0;
        if (px < 0) begin px = 0; clp = 1; end
        else if (px > mx) begin px = mx; clp = 1; end
        if (py < 0) begin py = 0; clp = 1; end
        else if (py > mx) begin py = mx; clp = 1; end
        if (md != 0) clp = 0;
        s = 0;
        for (int i = 0; i < 64; i++) res[i] = 0;
        for (int r = 0; r < mb; r++)
            for (int c = 0; c < mb; c++) begin
                p = (md != 0) ? 128 : m_ref[py + r][px + c];
                res[r * mb + c] = m_curr[r][c] - p;
                s += (res[r * mb + c] < 0) ? -res[r * mb + c] : res[r * mb + c];
            end
    endtask

    task automatic send4(input int md, input int mvx, input int mvy);
        int res [64];
        int s, clp, w;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ref4[r][c] = 8'(m_ref[r][c]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) curr4[r][c] = 8'(m_curr[r][c]);
        mode = md[0];
        mv_x = 6'(mvx);
        mv_y = 6'(mvy);
        w = 0;
        while (!src_ready4 && w < 20) begin @(posedge clk); #1; w++; end
        chk("src_ready4_wait", int'(src_ready4), 1);
        src_valid4 = 1'b1;
        model(4, 16, md, mvx, mvy, res, s, clp);
        for (int i = 0; i < 16; i++) qres4.push_back(res[i]);
        qsad4.push_back(s);
        qclp4.push_back(clp);
        @(posedge clk); #1;
        src_valid4 = 1'b0;
        // Inputs may change once accepted.
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ref4[r][c] = 8'($urandom);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) curr4[r][c] = 8'($urandom);
        mv_x = 6'($urandom);
        mv_y = 6'($urandom);
    endtask

    task automatic recv4(input int hold);
        int lat, es, ec;
        lat = 0;
        while (!dst_valid4 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("latency4", lat, 4);
        es = qsad4.pop_front();
        ec = qclp4.pop_front();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) chk("residual4", int'(res4[r][c]), qres4.pop_front());
        chk("sad4", int'(sad4), es);
        chk("mv_clamped4", int'(mvc4), ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_sad4", int'(sad4), es);
            chk("hold_dst_valid4", int'(dst_valid4), 1);
            chk("hold_src_ready4", int'(src_ready4), 0);
        end
        dst_ready = 1'b1;
        @(posedge clk); #1;
        dst_ready = 1'b0;
        chk("handshake_dst_valid4", int'(dst_valid4), 0);
        chk("handshake_src_ready4", int'(src_ready4), 1);
    endtask

    task automatic fill(input int ref_mode, input int curr_val);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                m_ref[r][c] = (ref_mode < 0) ? ((r * 16 + c) & 255) : ref_mode;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_curr[r][c] = (curr_val < 0) ? int'($urandom_range(0, 255)) : curr_val;
    endtask

    initial begin
        int res [64];
        int s, clp, w, lat;
        reset = 1'b1;
        src_valid4 = 1'b0; src_valid8 = 1'b0;
        dst_ready = 1'b0; mode = 1'b0; mv_x = '0; mv_y = '0;
        for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) ref8[r][c] = '0;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) ref4[r][c] = '0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) curr8[r][c] = '0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) curr4[r][c] = '0;

        #12;
        chk("rst_src_ready4", int'(src_ready4), 0);
        chk("rst_dst_valid4", int'(dst_valid4), 0);
        chk("rst_sad4", int'(sad4), 0);
        chk("rst_mvc4", int'(mvc4), 0);
        chk("rst_res4_00", int'(res4[0][0]), 0);
        chk("rst_src_ready8", int'(src_ready8), 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_src_ready4", int'(src_ready4), 1);

        // Centre MV, ramp reference.
        fill(-1, 100);
        send4(0, 0, 0);
        recv4(0);
        chk("res4_00_centre", int'(res4[0][0]), -2);
        chk("res4_33_centre", int'(res4[3][3]), -53);

        // Both MV components clamped.
        send4(0, -31, 20);
        recv4(0);
        chk("mvc4_clamped", int'(mvc4), 1);
        chk("res4_00_clamped", int'(res4[0][0]), 100 - 192);

        // Flat prediction ignores MV.
        fill(-1, 0);
        send4(1, -31, 20);
        recv4(0);
        chk("flat_res4_21", int'(res4[2][1]), -128);
        chk("flat_sad4", int'(sad4), 2048);
        chk("flat_mvc4", int'(mvc4), 0);

        // Backpressure for ten cycles.
        fill(-1, -1);
        send4(0, 3, -2);
        recv4(10);

        // Reset during the second CALC cycle aborts the block.
        fill(-1, 100);
        send4(1, 0, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("abort_src_ready4", int'(src_ready4), 0);
        chk("abort_dst_valid4", int'(dst_valid4), 0);
        chk("abort_sad4", int'(sad4), 0);
        for (int i = 0; i < 16; i++) void'(qres4.pop_back());
        void'(qsad4.pop_back());
        void'(qclp4.pop_back());
        @(posedge clk); #3;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_dst_valid4", int'(dst_valid4), 0);
        end
        send4(0, 1, 1);
        recv4(0);

        // Extremes.
        fill(0, 255);
        send4(0, 0, 0);
        recv4(0);
        chk("ext_pos_res4", int'(res4[1][2]), 255);
        fill(255, 0);
        send4(0, 0, 0);
        recv4(0);
        chk("ext_neg_res4", int'(res4[3][0]), -255);
        chk("ext_neg_sad4", int'(sad4), 4080);

        // 8x8 block in a 32x32 window, all 255 against 0.
        fill(0, 255);
        for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) ref8[r][c] = 8'(m_ref[r][c]);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) curr8[r][c] = 8'(m_curr[r][c]);
        mode = 1'b0; mv_x = 6'(-5); mv_y = 6'(7);
        w = 0;
        while (!src_ready8 && w < 20) begin @(posedge clk); #1; w++; end
        chk("src_ready8_wait", int'(src_ready8), 1);
        src_valid8 = 1'b1;
        model(8, 32, 0, -5, 7, res, s, clp);
        for (int i = 0; i < 64; i++) qres8.push_back(res[i]);
        qsad8.push_back(s);
        qclp8.push_back(clp);
        @(posedge clk); #1;
        src_valid8 = 1'b0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) curr8[r][c] = 8'($urandom);
        lat = 0;
        while (!dst_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("latency8", lat, 8);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) chk("residual8", int'(res8[r][c]), qres8.pop_front());
        chk("sad8", int'(sad8), qsad8.pop_front());
        chk("sad8_full_scale", int'(sad8), 16320);
        chk("mv_clamped8", int'(mvc8), qclp8.pop_front());
        dst_ready = 1'b1;
        @(posedge clk); #1;
        dst_ready = 1'b0;
        chk("handshake_dst_valid8", int'(dst_valid8), 0);
        chk("handshake_src_ready8", int'(src_ready8), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
